// File: rtl/inst_bus_bridge.sv
// Instruction fetch bridge: ROM-style zero-latency fetch port to a req/ack memory, with a
// one-word holding buffer. Optional bus timeout/abort enabled by defining IFB_TIMEOUT_EN.
module inst_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        err_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        held_valid_q, held_valid_d;
    logic [29:0] held_addr_q, held_addr_d;
    logic [31:0] held_data_q, held_data_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        err_q, err_d;
    logic        hit;

`ifdef IFB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Byte-offset bits never take part in the match; the parameter only matters with the timeout.
    logic unused_sink;
    assign unused_sink = ^{cpu_addr_i[1:0], 32'(TIMEOUT_CYCLES)};

    assign hit        = held_valid_q && (held_addr_q == cpu_addr_i[31:2]);
    assign stallreq_o = !rst && cpu_ce_i && !hit;
    assign cpu_data_o = (!rst && cpu_ce_i && hit) ? held_data_q : 32'h0;
    assign bus_req_o  = bus_req_q;
    assign bus_addr_o = bus_addr_q;
    assign err_o      = err_q;

    always_comb begin
        state_d      = state_q;
        held_valid_d = held_valid_q;
        held_addr_d  = held_addr_q;
        held_data_d  = held_data_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        err_d        = 1'b0;
`ifdef IFB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (cpu_ce_i && !hit) begin
                    state_d    = StBusy;
                    bus_req_d  = 1'b1;
                    bus_addr_d = {cpu_addr_i[31:2], 2'b00};
`ifdef IFB_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            StBusy: begin
                // Fill completes even if the core dropped ce or moved the PC meanwhile.
                if (bus_ack_i) begin
                    state_d      = StIdle;
                    bus_req_d    = 1'b0;
                    held_valid_d = 1'b1;
                    held_addr_d  = bus_addr_q[31:2];
                    held_data_d  = bus_rdata_i;
                end
`ifdef IFB_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    // Abort: park a NOP in the buffer so the core can move on.
                    state_d      = StIdle;
                    bus_req_d    = 1'b0;
                    held_valid_d = 1'b1;
                    held_addr_d  = bus_addr_q[31:2];
                    held_data_d  = 32'h0;
                    err_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            held_valid_q <= 1'b0;
            held_addr_q  <= 30'h0;
            held_data_q  <= 32'h0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_valid_q <= held_valid_d;
            held_addr_q  <= held_addr_d;
            held_data_q  <= held_data_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            err_q        <= err_d;
        end
    end

`ifdef IFB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_inst_bus_bridge.sv
// Scoreboard bench for inst_bus_bridge: stimulus queues expected fetch data and bus addresses,
// a negedge monitor pops and compares them as the bridge delivers words and issues requests.
module tb_inst_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ce_i = 1'b0;
    logic [31:0] cpu_addr_i = 32'h0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] cur_exp_addr = 32'h0;
    logic [31:0] popped;
    logic        req_prev = 1'b0;
    int          req_cycles = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    int          err_pulses = 0;

    // Memory model
    logic [31:0] mem_data = 32'h0;
    int          mem_wait = 0;
    int          mem_cnt = 0;
    bit          mem_en = 1'b1;

    always #5 clk = ~clk;

    inst_bus_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i),
        .err_o      (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Acks after mem_wait request cycles; ack is driven at negedge and sampled at the next posedge.
    always @(negedge clk) begin
        if (rst || !bus_req_o) begin
            bus_ack_i = 1'b0;
            mem_cnt   = 0;
        end else if (mem_en && mem_cnt == mem_wait) begin
            bus_ack_i   = 1'b1;
            bus_rdata_i = mem_data;
            mem_cnt++;
        end else begin
            bus_ack_i = 1'b0;
            mem_cnt++;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            req_prev = 1'b0;
        end else begin
            if (cpu_ce_i && !stallreq_o) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: got %h expected no delivery", cpu_data_o);
                end else begin
                    popped = exp_data.pop_front();
                    check("fetch_data", cpu_data_o, popped);
                end
            end
            if (!cpu_ce_i) begin
                check("idle_data", cpu_data_o, 32'h0);
                check("idle_stall", {31'b0, stallreq_o}, 32'h0);
            end
            if (bus_req_o) begin
                req_cycles++;
                if (!req_prev) begin
                    pulses++;
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected: got req addr %h expected no request",
                                 bus_addr_o);
                    end else begin
                        cur_exp_addr = exp_addr.pop_front();
                    end
                end
                check("bus_addr", bus_addr_o, cur_exp_addr);
            end
            if (err_o) err_pulses++;
            req_prev = bus_req_o;
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits,
                         input int exp_stall, input bit exp_req);
        int n;
        mem_data = data;
        mem_wait = waits;
        if (exp_req) begin
            exp_addr.push_back({addr[31:2], 2'b00});
            exp_pulses++;
        end
        exp_data.push_back(data);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = addr;
        n = 0;
        @(negedge clk);
        while (stallreq_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, exp_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) exp_data.push_back(d);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_ce_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with ce asserted: outputs must stay quiet.
        cpu_ce_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, stallreq_o}, 32'h0);
        check("rst_data", cpu_data_o, 32'h0);
        check("rst_req", {31'b0, bus_req_o}, 32'h0);
        check("rst_addr", bus_addr_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait miss, then 3-wait miss.
        fetch(32'h0000_0000, 32'h3401_1100, 0, 2, 1'b1);
        check("pulses_t1", pulses, 1);
        req_cycles = 0;
        fetch(32'h0000_0004, 32'hDEAD_BEEF, 3, 5, 1'b1);
        check("req_cycles_t2", req_cycles, 4);

        // Held PC is served from the buffer; byte offset ignored.
        hold(10, 32'hDEAD_BEEF);
        fetch(32'h0000_0006, 32'hDEAD_BEEF, 0, 0, 1'b0);
        check("pulses_t3", pulses, 2);

        // Reset mid-BUSY drops the request at once and invalidates the buffer.
        mem_en = 1'b0;
        exp_addr.push_back(32'h0000_0100);
        exp_pulses++;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0100;
        @(negedge clk);
        @(negedge clk);
        check("busy_req", {31'b0, bus_req_o}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_req_drop", {31'b0, bus_req_o}, 32'h0);
        check("rst_stall_busy", {31'b0, stallreq_o}, 32'h0);
        check("rst_data_busy", cpu_data_o, 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mem_en = 1'b1;
        fetch(32'h0000_0100, 32'h0BAD_F00D, 1, 3, 1'b1);

        // ce dropped during BUSY: transaction completes, then a hit without a new request.
        mem_data   = 32'h1234_5678;
        mem_wait   = 3;
        req_cycles = 0;
        exp_addr.push_back(32'h0000_0200);
        exp_pulses++;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0200;
        @(posedge clk);
        #1;
        cpu_ce_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ce_low_req_held", {31'b0, bus_req_o}, 32'h1);
        end
        idle(4);
        check("req_cycles_ce_low", req_cycles, 4);
        fetch(32'h0000_0200, 32'h1234_5678, 0, 0, 1'b0);
        check("pulses_ce_low", pulses, exp_pulses);

`ifdef IFB_TIMEOUT_EN
        // No ack: abort after 4 request cycles, NOP delivered, one err pulse.
        mem_en     = 1'b0;
        req_cycles = 0;
        fetch(32'h0000_0300, 32'h0000_0000, 0, 5, 1'b1);
        mem_en = 1'b1;
        idle(3);
        check("timeout_req_cycles", req_cycles, 4);
        check("timeout_err_pulses", err_pulses, 1);
        // Ack arriving in the expiry cycle wins.
        fetch(32'h0000_0400, 32'hCAFE_F00D, 3, 5, 1'b1);
        idle(3);
        check("ack_at_expiry_err", err_pulses, 1);
`else
        idle(3);
        check("err_never", err_pulses, 0);
`endif

        check("pulses_total", pulses, exp_pulses);
        check("exp_data_left", exp_data.size(), 0);
        check("exp_addr_left", exp_addr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/inst_bus_bridge.md
# inst_bus_bridge

- Instruction-side bridge between the core's ROM-style fetch port (`rom_ce_o`, `rom_addr_o`, `rom_data_i`) and an external memory with variable latency and a req/ack handshake.
- Raises a stall request to `ctrl` until the word for the current PC has been fetched, then presents it to IF/ID.
- Keeps a one-word holding buffer, so a PC held by a stall is served without re-fetching.
- Sits directly downstream of the core's fetch port, in place of the zero-latency instruction ROM.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without ack before abort. Range 1..255. Used only with IFB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_ce_i  in  1  fetch enable from the core's `rom_ce_o`
- cpu_addr_i  in  32  fetch address (PC) from `rom_addr_o`
- cpu_data_o  out  32  instruction to the core's `rom_data_i`
- stallreq_o  out  1  stall request to `ctrl`, used as an IF-stage stall source
- bus_req_o  out  1  memory read request, registered
- bus_addr_o  out  32  word-aligned read address, registered
- bus_ack_i  in  1  memory acknowledge; `bus_rdata_i` is valid in the same cycle
- bus_rdata_i  in  32  memory read data
- err_o  out  1  one-cycle timeout pulse, registered

## Operation
- Internal state: state ∈ {IDLE, BUSY}, held_valid, held_addr[31:2], held_data[31:0].
- hit = held_valid && held_addr == cpu_addr_i[31:2]. Address bits [1:0] are ignored everywhere.
- Combinational outputs:
  - stallreq_o = !rst && cpu_ce_i && !hit.
  - cpu_data_o = held_data when (!rst && cpu_ce_i && hit), else 32'h0 (NOP).
- IDLE:
  - If cpu_ce_i && !hit: go to BUSY, set bus_req_o=1, bus_addr_o={cpu_addr_i[31:2],2'b00}.
  - Otherwise stay in IDLE with bus_req_o=0.
- BUSY:
  - bus_req_o and bus_addr_o hold stable until ack. A request is never withdrawn except by reset or timeout.
  - On an edge with bus_ack_i=1: held_data=bus_rdata_i, held_addr=bus_addr_o[31:2], held_valid=1, bus_req_o=0, go to IDLE.
  - cpu_ce_i falling or cpu_addr_i changing during BUSY does not cancel the transaction. It completes and fills the buffer. The next IDLE cycle then re-evaluates hit.
- bus_ack_i is ignored in IDLE.
- No back-to-back requests: at least one IDLE cycle separates consecutive bus_req_o pulses.

## Timing
- Reset values: state=IDLE, bus_req_o=0, bus_addr_o=0, err_o=0, held_valid=0, held_addr=0, held_data=0, timeout counter=0. stallreq_o=0 and cpu_data_o=0 while rst=1.
- Miss latency with zero-wait memory (ack in the first BUSY cycle):
  - Cycle 0: new address, miss, stallreq=1.
  - Cycle 1: BUSY, req=1, ack=1.
  - Cycle 2: hit, stallreq=0, instruction valid.
- Miss latency with W wait cycles: stallreq_o is high for 2+W cycles.
- Hit latency: zero. Data is combinational from the buffer in the same cycle.
- Reset during BUSY: bus_req_o drops immediately (async); the buffer is invalidated.

## Configuration
- Macro IFB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: bus_req_o=0, held_data=32'h0, held_addr=bus_addr_o[31:2], held_valid=1, err_o=1 for exactly one cycle, go to IDLE. The core then executes a NOP.
  - Ack in the same cycle as expiry: ack wins, err_o stays 0.
- Undefined: no counter, BUSY waits indefinitely, err_o tied to 0.

## Test plan
- Reset, then cpu_ce_i=1, addr=0x0000_0000, memory returns 0x3401_1100 with zero wait. Required: stallreq high 2 cycles; cycle 2 cpu_data_o=0x3401_1100, stallreq=0; exactly one req pulse with bus_addr_o=0x0.
- Addr 0x0000_0004, ack after 3 wait cycles with data 0xDEAD_BEEF. Required: stallreq high 5 cycles; bus_addr_o stable at 0x4 while req=1; data 0xDEAD_BEEF afterwards.
- Same address held for 10 cycles after a fill. Required: no further req pulses; cpu_data_o constant; addr 0x0000_0006 also hits (bits [1:0] ignored).
- Assert rst mid-BUSY. Required: req drops in the same cycle; after release, the same address misses and is re-requested.
- Drop cpu_ce_i during BUSY. Required: req held until ack; cpu_data_o=0 and stallreq=0 while ce=0; re-raising ce at the same address hits with no new request.
- IFB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack. Required: req high 4 cycles then drops; err_o pulses exactly once; cpu_data_o=0 and stallreq=0 next cycle. Rerun with ack at the expiry cycle: err_o stays 0 and ack data is used.
